// File: rtl/sram_pkt_reader.sv
// Read-side initiator for the banked packet SRAM: turns (address, length) commands into
// one-per-cycle SRAM reads and streams the returned words out with sop/eop framing.
module sram_pkt_reader #(
    parameter int DWIDTH     = 32,
    parameter int NRAMWIDHT  = 5,
    parameter int AWIDTH     = 13,
    parameter int LENWIDTH   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        cmd_valid_in,
    output logic                        cmd_ready_out,
    input  logic [NRAMWIDHT+AWIDTH-1:0] cmd_addr_in,
    input  logic [LENWIDTH-1:0]         cmd_len_in,
    output logic                        sram_en_out,
    output logic                        sram_we_out,
    output logic [NRAMWIDHT+AWIDTH-1:0] sram_addr_out,
    input  logic [DWIDTH-1:0]           sram_d_in,
    output logic                        dout_valid_out,
    input  logic                        dout_ready_in,
    output logic [DWIDTH-1:0]           dout_data_out,
    output logic                        dout_sop_out,
    output logic                        dout_eop_out,
    output logic                        busy_out
);

    localparam int ADDR_W = NRAMWIDHT + AWIDTH;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic [LENWIDTH-1:0] remain_reg;
    logic                first_reg;
    logic                inflight_reg;
    logic                sop_d_reg;
    logic                eop_d_reg;

    logic [DWIDTH-1:0]   fifo_data [FIFO_DEPTH];
    logic                fifo_sop  [FIFO_DEPTH];
    logic                fifo_eop  [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg, count_next;

    logic                accept;
    logic                issue;
    logic                push;
    logic                pop;
    logic                last_issue;
    logic [CNT_W:0]      credit_used;

    // Credits count both stored words and the read whose data is still on the SRAM bus,
    // so the capture in the following cycle always has a free slot.
    assign credit_used = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};
    assign issue       = (state_reg == READ) && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign last_issue  = issue && (remain_reg == LENWIDTH'(1));
    assign accept      = cmd_valid_in && (state_reg == IDLE);
    assign push        = inflight_reg;
    assign pop         = (count_reg != '0) && dout_ready_in;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && (cmd_len_in != '0)) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (last_issue) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as soon as the final word is being popped so the next command
                // can be handshaken in the very next cycle.
                if (!inflight_reg && (count_next == '0)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            remain_reg   <= '0;
            first_reg    <= 1'b0;
            inflight_reg <= 1'b0;
            sop_d_reg    <= 1'b0;
            eop_d_reg    <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= issue;
            sop_d_reg    <= issue && first_reg;
            eop_d_reg    <= last_issue;
            count_reg    <= count_next;
            if (accept && (cmd_len_in != '0)) begin
                addr_reg   <= cmd_addr_in;
                remain_reg <= cmd_len_in;
                first_reg  <= 1'b1;
            end else if (issue) begin
                addr_reg   <= addr_reg + ADDR_W'(1);
                remain_reg <= remain_reg - LENWIDTH'(1);
                first_reg  <= 1'b0;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    // Storage carries no reset; the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_data[wr_ptr_reg] <= sram_d_in;
            fifo_sop[wr_ptr_reg]  <= sop_d_reg;
            fifo_eop[wr_ptr_reg]  <= eop_d_reg;
        end
    end

    assign cmd_ready_out  = (state_reg == IDLE);
    assign busy_out       = (state_reg != IDLE);
    assign sram_en_out    = issue;
    assign sram_we_out    = 1'b0;
    assign sram_addr_out  = addr_reg;
    assign dout_valid_out = (count_reg != '0);
    assign dout_data_out  = dout_valid_out ? fifo_data[rd_ptr_reg] : '0;
    assign dout_sop_out   = dout_valid_out && fifo_sop[rd_ptr_reg];
    assign dout_eop_out   = dout_valid_out && fifo_eop[rd_ptr_reg];

endmodule

// File: tb/tb_sram_pkt_reader.sv
// Directed and randomised checks of sram_pkt_reader against an SRAM model holding word = address.
module tb_sram_pkt_reader;

    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_q;
    logic          dout_valid;
    logic          dout_ready;
    logic [31:0]   dout_data;
    logic          dout_sop;
    logic          dout_eop;
    logic          busy;

    sram_pkt_reader dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .cmd_valid_in  (cmd_valid),
        .cmd_ready_out (cmd_ready),
        .cmd_addr_in   (cmd_addr),
        .cmd_len_in    (cmd_len),
        .sram_en_out   (sram_en),
        .sram_we_out   (sram_we),
        .sram_addr_out (sram_addr),
        .sram_d_in     (sram_q),
        .dout_valid_out(dout_valid),
        .dout_ready_in (dout_ready),
        .dout_data_out (dout_data),
        .dout_sop_out  (dout_sop),
        .dout_eop_out  (dout_eop),
        .busy_out      (busy)
    );

    always #5 clk = ~clk;

    // One-cycle-latency SRAM whose contents equal the word address; zero when not enabled.
    always @(posedge clk) sram_q <= sram_en ? {14'd0, sram_addr} : 32'd0;

    int cyc = 0;
    int t0  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct { int rel; logic [AW-1:0] addr; } iss_t;
    typedef struct { int rel; logic [31:0] data; logic sop; logic eop; } out_t;

    iss_t        iss_q[$];
    out_t        out_q[$];
    bit          done_seen;
    int          done_rel;
    logic        busy1;
    int          n_issued;
    int          n_popped;
    int          rdy_mode;

    // Monitor: logs issues and accepted words, checks credits and stall stability.
    initial begin
        bit          stalled_prev;
        logic [33:0] prev_word;
        int          rel;
        stalled_prev = 1'b0;
        prev_word    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled_prev = 1'b0;
            end else begin
                rel = cyc - t0 + 1;
                if (rel == 1) busy1 = busy;
                if (sram_en) begin
                    check("credit", 64'(n_issued - n_popped < 4), 64'd1);
                    iss_q.push_back('{rel, sram_addr});
                    n_issued++;
                end
                if (stalled_prev)
                    check("stall_hold", {dout_valid, dout_data, dout_sop, dout_eop}, {1'b1, prev_word});
                if (dout_valid && dout_ready) begin
                    out_q.push_back('{rel, dout_data, dout_sop, dout_eop});
                    n_popped++;
                end
                stalled_prev = dout_valid && !dout_ready;
                prev_word    = {dout_data, dout_sop, dout_eop};
                if (!done_seen && cmd_ready) begin
                    done_seen = 1'b1;
                    done_rel  = rel;
                end
            end
        end
    end

    // Ready pattern: 0 = always high, 1 = random 50%, 2 = low for cycles 3..12.
    initial begin
        int r;
        dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            r = cyc - t0 + 1;
            case (rdy_mode)
                1:       dout_ready = 1'($urandom_range(0, 1));
                2:       dout_ready = !(r >= 3 && r <= 12);
                default: dout_ready = 1'b1;
            endcase
        end
    end

    task automatic check_reset_values();
        check("rst_flags", {cmd_ready, sram_en, sram_we, dout_valid, dout_sop, dout_eop, busy}, 7'b1000000);
        check("rst_addr", sram_addr, 0);
        check("rst_data", dout_data, 0);
    endtask

    task automatic send_cmd(input logic [AW-1:0] a, input logic [7:0] l);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        t0        = cyc;
        iss_q.delete();
        out_q.delete();
        done_seen = 1'b0;
        done_rel  = -1;
        busy1     = 1'bx;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            #1;
            if (done_seen) break;
        end
        check("idle_reached", done_seen, 1);
    endtask

    task automatic check_issues(input logic [AW-1:0] base, input int len);
        check("issue_count", iss_q.size(), len);
        for (int i = 0; i < len; i++) begin
            if (i < iss_q.size()) begin
                check($sformatf("issue_addr[%0d]", i), iss_q[i].addr, AW'(base + AW'(i)));
                check($sformatf("issue_cycle[%0d]", i), iss_q[i].rel, 1 + i);
            end
        end
    endtask

    task automatic check_words(input logic [AW-1:0] base, input int len, input int first_rel);
        logic [AW-1:0] a;
        check("word_count", out_q.size(), len);
        for (int i = 0; i < len; i++) begin
            if (i < out_q.size()) begin
                a = base + AW'(i);
                check($sformatf("word[%0d]", i), {out_q[i].data, out_q[i].sop, out_q[i].eop},
                      {14'd0, a, 1'(i == 0), 1'(i == len - 1)});
                if (first_rel >= 0)
                    check($sformatf("word_cycle[%0d]", i), out_q[i].rel, first_rel + i);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_early;
        int          n_gap;
        logic [AW-1:0] ra;
        logic [7:0]  rl;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        rdy_mode  = 0;
        n_issued  = 0;
        n_popped  = 0;
        done_seen = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Single read, ready high.
        send_cmd(18'h00010, 8'd4);
        wait_idle(50);
        check("busy_cycle1", busy1, 1);
        check_issues(18'h00010, 4);
        check_words(18'h00010, 4, 3);
        check("ready_again_cycle", done_rel, 7);

        // Bank crossing and top-address wrap.
        send_cmd(18'h01FFF, 8'd3);
        wait_idle(50);
        check_issues(18'h01FFF, 3);
        check_words(18'h01FFF, 3, 3);
        send_cmd(18'h3FFFF, 8'd3);
        wait_idle(50);
        check_issues(18'h3FFFF, 3);
        check_words(18'h3FFFF, 3, 3);
        check("wrap_ready_cycle", done_rel, 6);

        // Zero and unit length.
        send_cmd(18'h00500, 8'd0);
        wait_idle(20);
        check("len0_issues", iss_q.size(), 0);
        check("len0_words", out_q.size(), 0);
        check("len0_busy", busy1, 0);
        check("len0_ready_cycle", done_rel, 1);
        send_cmd(18'h00777, 8'd1);
        wait_idle(20);
        check_words(18'h00777, 1, 3);
        check("len1_ready_cycle", done_rel, 4);

        // Backpressure: ready low for cycles 3..12.
        rdy_mode = 2;
        send_cmd(18'h00400, 8'd16);
        wait_idle(200);
        n_early = 0;
        n_gap   = 0;
        foreach (iss_q[i]) begin
            if (iss_q[i].rel <= 4) n_early++;
            if (iss_q[i].rel >= 5 && iss_q[i].rel <= 13) n_gap++;
        end
        check("bp_issues_before_stall", n_early, 4);
        check("bp_issues_during_stall", n_gap, 0);
        check("bp_total_issues", iss_q.size(), 16);
        check_words(18'h00400, 16, 13);
        rdy_mode = 0;

        // Reset during word 5 of a len-10 read.
        send_cmd(18'h00100, 8'd10);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (cyc - t0 + 1 == 7) break;
        end
        check("pre_reset_words", out_q.size(), 5);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n    = 1'b1;
        n_issued = 0;
        n_popped = 0;
        @(negedge clk);
        #1;
        send_cmd(18'h00200, 8'd2);
        wait_idle(30);
        check_issues(18'h00200, 2);
        check_words(18'h00200, 2, 3);

        // Random ready over back-to-back random commands.
        rdy_mode = 1;
        for (int c = 0; c < 100; c++) begin
            ra = AW'($urandom_range(0, (1 << AW) - 1));
            rl = 8'($urandom_range(0, 20));
            send_cmd(ra, rl);
            wait_idle(40 * int'(rl) + 40);
            check_words(ra, int'(rl), -1);
        end
        rdy_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_pkt_reader.md
# sram_pkt_reader

Read-side initiator for the banked dual-port packet SRAM. Accepts a read command (start address, word count), issues one read per cycle on an SRAM port, captures the one-cycle-latency read data and streams it out on a valid/ready interface with start/end-of-packet flags. Credit-based issue into a small output FIFO absorbs downstream backpressure without losing in-flight reads. Sits between the packet cache and the egress port logic.

## Interface
- DWIDTH, 32, data word width; equals the SRAM data width
- NRAMWIDHT, 5, bank-select bits (2^NRAMWIDHT banks)
- AWIDTH, 13, per-bank word address bits
- LENWIDTH, 8, command length field width, in words
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2

Ports:
- clk_in  input  1  clock; single clock domain
- rst_n_in  input  1  asynchronous, active-low reset
- cmd_valid_in  input  1  command valid
- cmd_ready_out  output  1  command accepted when high together with cmd_valid_in
- cmd_addr_in  input  NRAMWIDHT+AWIDTH  start word address; upper NRAMWIDHT bits select the bank
- cmd_len_in  input  LENWIDTH  number of words to read
- sram_en_out  output  1  SRAM port enable
- sram_we_out  output  1  SRAM write enable; constant 0
- sram_addr_out  output  NRAMWIDHT+AWIDTH  SRAM word address
- sram_d_in  input  DWIDTH  SRAM read data; valid the cycle after sram_en_out; reads as 0 otherwise
- dout_valid_out  output  1  output word valid
- dout_ready_in  input  1  downstream ready
- dout_data_out  output  DWIDTH  output word
- dout_sop_out  output  1  first word of the command
- dout_eop_out  output  1  last word of the command
- busy_out  output  1  high whenever state is not IDLE

## Operation
- States: IDLE, READ, DRAIN.
- IDLE:
  - cmd_ready_out = 1.
  - On handshake with cmd_len_in = 0: command consumed, no reads, no output; remain IDLE.
  - Otherwise latch the address and length (remaining = len) and go to READ.
- READ: a read is issued in a cycle iff fifo_count + inflight < FIFO_DEPTH.
  - inflight is 0 or 1: the read issued in the previous cycle.
  - An issue drives sram_en_out = 1 and sram_addr_out = current address.
  - The current address then increments modulo 2^(NRAMWIDHT+AWIDTH), so a bank boundary is crossed transparently and the top address wraps to 0.
  - Each issue decrements remaining.
  - Each issue is tagged sop (first issue of the command) and eop (remaining = 1); the tag is delayed one cycle alongside the read.
  - After the eop issue, go to DRAIN.
- DRAIN: wait until inflight = 0 and the FIFO is empty, then go to IDLE.
- Capture: in the cycle after an issue, {sram_d_in, sop, eop} is written into the FIFO. sram_d_in is ignored in all other cycles.
- Output:
  - dout_* present the FIFO head; dout_valid_out = FIFO not empty.
  - A pop occurs when dout_valid_out && dout_ready_in.
  - Push and pop in the same cycle leave the count unchanged.
- cmd_ready_out is 0 in READ and DRAIN; a new command is accepted only in IDLE.
- Credit rule: the FIFO never overflows, and data is never dropped or duplicated under any dout_ready_in pattern.

## Timing
- Reset values while rst_n_in is low:
  - sram_en_out, sram_we_out, dout_valid_out, dout_sop_out, dout_eop_out, busy_out = 0.
  - sram_addr_out and dout_data_out = 0.
  - cmd_ready_out = 1; state = IDLE; FIFO and inflight cleared.
- Reset asserted mid-command aborts it immediately. Outstanding read data is discarded. After release the block is in IDLE with cmd_ready_out = 1.
- Command handshake at edge E0 (registered):
  - busy_out high from cycle 1.
  - First sram_en_out in cycle 1.
  - Data captured at the end of cycle 2.
  - First dout_valid_out in cycle 3.
- Handshake to first output word is 3 cycles.
- With dout_ready_in held high:
  - One word per cycle.
  - Length-L command: outputs in cycles 3..L+2.
  - IDLE (cmd_ready_out = 1) in cycle L+3.
- Minimum command spacing is L+3 cycles.
- Stall: dout_ready_in low holds dout_* stable. Issue stops once fifo_count + inflight reaches FIFO_DEPTH. Issue resumes in the cycle after a pop frees a credit.
- L = 1: sop and eop are asserted on the same word.

## Test plan
- Single read: cmd addr 0x00010, len 4, ready high, SRAM preloaded with word = address.
  - Expect sram_en cycles 1–4 at addresses 0x10–0x13.
  - Expect dout 0x10..0x13 in cycles 3–6, with sop on 0x10 and eop on 0x13.
  - Expect cmd_ready_out high again in cycle 7.
- Bank crossing and wrap, each with len 3:
  - addr 0x01FFF: expect addresses 0x01FFF, 0x02000, 0x02001.
  - addr 0x3FFFF: expect 0x3FFFF, 0x00000, 0x00001.
- Backpressure: len 16 with dout_ready_in low for cycles 3–12.
  - Expect at most 4 issues before the stall.
  - Expect all 16 words delivered in order, none duplicated.
  - Expect dout_data_out stable while stalled.
- Zero and unit length:
  - len 0: no sram_en_out, no dout_valid_out, cmd_ready_out stays 1.
  - len 1: a single word with sop = eop = 1.
- Reset mid-command: assert rst_n_in low during word 5 of a len-10 read.
  - Expect all outputs at reset values.
  - After release, a fresh len-2 command returns exactly 2 correct words.
- Random ready: random dout_ready_in at 50% over 100 back-to-back random commands.
  - Scoreboard all words against the SRAM model: order, data, sop/eop, and no overflow.
